cigar_encoder: RTL and testbench
================================

Name: cigar_encoder

Overview:
- Downstream consumer of the traceback stage: takes the per-cycle alignment op stream (alignment_out / alignment_valid / done) and run-length encodes it into CIGAR entries (op, length).
- Entries are buffered in a small first-word-fall-through FIFO and drained by the host with a valid/ready handshake.
- The traceback stage has no backpressure input, so the encoder never stalls its input; FIFO overflow is flagged instead.

Parameters:
- OP_WIDTH, 2, op code width; equals `BP_WIDTH. Codes: 00 match, 01 mismatch, 10 insertion, 11 deletion.
- LEN_WIDTH, 12, run-length counter width; max run is 2^LEN_WIDTH-1.
- FIFO_DEPTH, 8, CIGAR entry FIFO depth (power of 2).
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse: new alignment begins (driven from tb_valid rising); clears the run and the overflow flag.
- op_i  in  OP_WIDTH  alignment op (traceback alignment_out).
- op_valid_i  in  1  op_i valid this cycle (traceback alignment_valid).
- done_i  in  1  one-cycle pulse: traceback finished (traceback done).
- cigar_op_o  out  OP_WIDTH  head entry op.
- cigar_len_o  out  LEN_WIDTH  head entry length.
- cigar_last_o  out  1  head entry is the final entry of the alignment.
- cigar_valid_o  out  1  FIFO not empty.
- cigar_ready_i  in  1  host accepts the head entry.
- busy_o  out  1  state is not IDLE.
- overflow_o  out  1  sticky: at least one entry was dropped on a full FIFO.
- entry_count_o  out  LEN_WIDTH  entries pushed for the current alignment.

Behaviour:
- Reset (reset_i=0, async): state IDLE; run_op=0, run_len=0; FIFO empty; all outputs 0.
- States and transitions:
  - IDLE --start_i--> RUN.
  - RUN --done_i--> FLUSH.
  - FLUSH --pending pushes complete--> IDLE.
  - start_i in any state aborts: run cleared, FIFO flushed, overflow_o/entry_count_o cleared, next state RUN.
- RUN, op_valid_i=1:
  - run_len==0: run_op<=op_i, run_len<=1.
  - op_i==run_op and run_len<max: run_len+1.
  - op_i==run_op and run_len==max: push (run_op, max, last=0); run_len<=1.
  - op_i!=run_op: push (run_op, run_len, last=0); run_op<=op_i, run_len<=1.
- done_i with op_valid_i in the same cycle: the op is applied first (rules above), then the flush. If that op itself caused a push, the final push happens in FLUSH on the next cycle.
- FLUSH: push (run_op, run_len, last=1), then clear the run.
- Empty alignment (run_len==0 at flush): push marker (op=00, len=0, last=1).
- op_valid_i in IDLE or FLUSH: ignored.
- Push latency: an entry is visible on cigar_valid_o one cycle after the triggering op/done.
- FIFO:
  - FWFT; pop when cigar_valid_o && cigar_ready_i.
  - A push and a pop in the same cycle are both legal when full; the count is unchanged.
  - A push when full without a pop is dropped and sets overflow_o. A dropped last entry is lost; the host detects this via overflow_o.
- entry_count_o increments on every accepted push and saturates at max.
- Outputs are registered or driven from FIFO storage; there is no combinational path from op_i to the outputs.

Optional Feature:
- CIGAR_MERGE_MISMATCH_EN defined: ops 00 and 01 are both mapped to 00 before comparison, so runs of match and mismatch merge into one SAM-style 'M' entry; op 01 never appears at the output.
- Not defined: match and mismatch are distinct ops ('='/'X' style).

Test Plan:
- start_i; ops 00,00,00,10,10,11; done_i -> entries (00,3,0), (10,2,0), (11,1,1); entry_count_o=3.
- start_i; 4096 consecutive op 00 (LEN_WIDTH=12); done_i -> (00,4095,0), (00,1,1).
- start_i; ops 00 then 01 with done_i in the same cycle as 01 -> (00,1,0) next cycle, then (01,1,1) one cycle later; busy_o drops after FLUSH.
- Hold cigar_ready_i=0; 10 alternating ops 10/11; done_i -> 8 entries held, overflow_o=1, last entry dropped. Then start_i -> FIFO empty, overflow_o=0.
- start_i then immediate done_i -> single marker (00,0,1).
- With CIGAR_MERGE_MISMATCH_EN: ops 00,01,00,11; done_i -> (00,3,0), (11,1,1). Without it: (00,1,0), (01,1,0), (00,1,0), (11,1,1).

Source files
------------

// File: rtl/cigar_encoder.sv
// -----------------------------------------------------------------------------
// cigar_encoder
//
// Run-length encodes the per-cycle alignment op stream from the traceback stage
// into CIGAR entries (op, length, last). Entries wait in a small
// first-word-fall-through FIFO until the host drains them. The traceback stage
// cannot be stalled, so a full FIFO drops the entry and raises a sticky flag.
//
// Optional feature macro: CIGAR_MERGE_MISMATCH_EN
//   defined   : match (00) and mismatch (01) fold into one 'M' op (00).
//   undefined : match and mismatch stay distinct ops.
//
// Ports:
//   clk            clock
//   reset_i        asynchronous, active-low reset
//   start_i        pulse: new alignment; aborts the current one, clears the
//                  run, the FIFO, overflow_o and entry_count_o
//   op_i           alignment op (00 match, 01 mismatch, 10 ins, 11 del)
//   op_valid_i     op_i valid this cycle (used only in RUN)
//   done_i         pulse: traceback finished
//   cigar_op_o     head entry op
//   cigar_len_o    head entry length
//   cigar_last_o   head entry is the final entry of the alignment
//   cigar_valid_o  FIFO not empty
//   cigar_ready_i  host accepts the head entry
//   busy_o         encoder is not idle
//   overflow_o     sticky: an entry was dropped on a full FIFO
//   entry_count_o  entries accepted into the FIFO for this alignment (saturating)
//
// Handshake: the head entry transfers on every rising clk edge where
// cigar_valid_o and cigar_ready_i are both 1. cigar_valid_o never depends on
// cigar_ready_i, and the head fields are stable while cigar_valid_o is held.
// -----------------------------------------------------------------------------
module cigar_encoder #(
    parameter int OP_WIDTH   = 2,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [OP_WIDTH-1:0]  op_i,
    input  logic                 op_valid_i,
    input  logic                 done_i,
    output logic [OP_WIDTH-1:0]  cigar_op_o,
    output logic [LEN_WIDTH-1:0] cigar_len_o,
    output logic                 cigar_last_o,
    output logic                 cigar_valid_o,
    input  logic                 cigar_ready_i,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [LEN_WIDTH-1:0] entry_count_o
);

    localparam int EW = OP_WIDTH + LEN_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = '1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [FIFO_AW:0]     CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]     CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0]   PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OP_WIDTH-1:0]    run_op_q, run_op_d;
    logic [LEN_WIDTH-1:0]   run_len_q, run_len_d;
    logic                   final_pend_q, final_pend_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [LEN_WIDTH-1:0]   entry_count_q, entry_count_d;

    logic [OP_WIDTH-1:0]    op_eff;
    logic [OP_WIDTH-1:0]    nxt_op;
    logic [LEN_WIDTH-1:0]   nxt_len;
    logic                   op_pushed;
    logic                   push_req;
    logic [EW-1:0]          push_entry;
    logic                   do_push;
    logic                   pop;
    logic                   fifo_clear;

`ifdef CIGAR_MERGE_MISMATCH_EN
    assign op_eff = (op_i == OP_WIDTH'(1)) ? '0 : op_i;
`else
    assign op_eff = op_i;
`endif

    // Effect of one op on the open run; op_pushed marks that the old run closed.
    always_comb begin
        nxt_op    = run_op_q;
        nxt_len   = run_len_q;
        op_pushed = 1'b0;
        if (op_valid_i) begin
            if (run_len_q == '0) begin
                nxt_op  = op_eff;
                nxt_len = LEN_ONE;
            end else if ((op_eff == run_op_q) && (run_len_q != LEN_MAX)) begin
                nxt_len = run_len_q + LEN_ONE;
            end else begin
                op_pushed = 1'b1;
                nxt_op    = op_eff;
                nxt_len   = LEN_ONE;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        run_op_d      = run_op_q;
        run_len_d     = run_len_q;
        final_pend_d  = final_pend_q;
        overflow_d    = overflow_q;
        entry_count_d = entry_count_q;
        push_req      = 1'b0;
        push_entry    = '0;
        fifo_clear    = 1'b0;

        if (start_i) begin
            state_d       = ST_RUN;
            run_op_d      = '0;
            run_len_d     = '0;
            final_pend_d  = 1'b0;
            overflow_d    = 1'b0;
            entry_count_d = '0;
            fifo_clear    = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (op_pushed) begin
                        push_req   = 1'b1;
                        push_entry = {run_op_q, run_len_q, 1'b0};
                    end
                    run_op_d  = nxt_op;
                    run_len_d = nxt_len;
                    if (done_i) begin
                        state_d = ST_FLUSH;
                        if (op_pushed) begin
                            // Only one push per cycle: the final entry waits a cycle.
                            final_pend_d = 1'b1;
                        end else begin
                            push_req   = 1'b1;
                            // An empty alignment still emits a (00, 0, last) marker.
                            push_entry = (nxt_len == '0) ? {{OP_WIDTH{1'b0}}, {LEN_WIDTH{1'b0}}, 1'b1}
                                                         : {nxt_op, nxt_len, 1'b1};
                            run_op_d   = '0;
                            run_len_d  = '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (final_pend_q) begin
                        push_req   = 1'b1;
                        push_entry = {run_op_q, run_len_q, 1'b1};
                    end
                    run_op_d     = '0;
                    run_len_d    = '0;
                    final_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
                default: ;
            endcase
        end

        // FIFO bookkeeping. A push on a full FIFO is accepted only when the
        // head leaves in the same cycle, freeing the slot it is written into.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        pop      = (count_q != '0) && cigar_ready_i;
        if (fifo_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_push = push_req && ((count_q != CNT_FULL) || pop);
            if (push_req && !do_push) begin
                overflow_d = 1'b1;
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
                if (entry_count_q != LEN_MAX) begin
                    entry_count_d = entry_count_q + LEN_ONE;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (do_push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!do_push && pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            run_op_q      <= '0;
            run_len_q     <= '0;
            final_pend_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            entry_count_q <= '0;
        end else begin
            state_q       <= state_d;
            run_op_q      <= run_op_d;
            run_len_q     <= run_len_d;
            final_pend_q  <= final_pend_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            entry_count_q <= entry_count_d;
        end
    end

    assign {cigar_op_o, cigar_len_o, cigar_last_o} = mem_q[rd_ptr_q];
    assign cigar_valid_o = (count_q != '0);
    assign busy_o        = (state_q != ST_IDLE);
    assign overflow_o    = overflow_q;
    assign entry_count_o = entry_count_q;

endmodule

// File: tb/tb_cigar_encoder.sv
// -----------------------------------------------------------------------------
// tb_cigar_encoder
//
// Bench for cigar_encoder: directed vector table, hand-written timing and
// overflow sequences, and randomized alignments checked against a run-splitting
// reference model. Honors CIGAR_MERGE_MISMATCH_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_cigar_encoder;

    localparam int OPW     = 2;
    localparam int LENW    = 12;
    localparam int EW      = OPW + LENW + 1;
    localparam int LEN_MAX = (1 << LENW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset_i = 1'b0;
    logic            start_i = 1'b0;
    logic [OPW-1:0]  op_i = '0;
    logic            op_valid_i = 1'b0;
    logic            done_i = 1'b0;
    logic            cigar_ready_i = 1'b0;
    logic [OPW-1:0]  cigar_op_o;
    logic [LENW-1:0] cigar_len_o;
    logic            cigar_last_o;
    logic            cigar_valid_o;
    logic            busy_o;
    logic            overflow_o;
    logic [LENW-1:0] entry_count_o;

    always #5 clk = ~clk;

    cigar_encoder #(.OP_WIDTH(OPW), .LEN_WIDTH(LENW), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .op_valid_i(op_valid_i), .done_i(done_i), .cigar_op_o(cigar_op_o),
        .cigar_len_o(cigar_len_o), .cigar_last_o(cigar_last_o),
        .cigar_valid_o(cigar_valid_o), .cigar_ready_i(cigar_ready_i),
        .busy_o(busy_o), .overflow_o(overflow_o), .entry_count_o(entry_count_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    int low_budget = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    logic [1:0]    stim_q[$];

    function automatic logic [EW-1:0] ent(input logic [1:0] op, input int len, input bit last);
        return {op, LENW'(len), last};
    endfunction

    function automatic logic [1:0] map_op(input logic [1:0] op);
`ifdef CIGAR_MERGE_MISMATCH_EN
        return (op == 2'b01) ? 2'b00 : op;
`else
        return op;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] head();
        return {cigar_op_o, cigar_len_o, cigar_last_o};
    endfunction

    // Every transfer the host accepts, in order.
    always @(negedge clk) begin
        if (reset_i && cigar_valid_o && cigar_ready_i) got_q.push_back(head());
    end

    // ---------------- driver ----------------
    task automatic cyc(input bit st, input bit v, input logic [1:0] op, input bit dn, input bit rdy);
        start_i = st; op_valid_i = v; op_i = op; done_i = dn; cigar_ready_i = rdy;
        @(posedge clk);
        #1;
        start_i = 1'b0; op_valid_i = 1'b0; done_i = 1'b0;
    endtask

    // At most 6 stalled host cycles per alignment, so the FIFO cannot fill.
    function automatic bit next_ready();
        if (low_budget < 6 && $urandom_range(0, 3) == 0) begin
            low_budget++;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- reference model ----------------
    // Split the op list into maximal runs of equal ops, cut each run into
    // chunks of at most LEN_MAX, mark the final chunk as last.
    task automatic build_expected();
        int i, j, run, c, n;
        logic [1:0] o;
        logic [EW-1:0] tail;
        exp_q.delete();
        n = stim_q.size();
        i = 0;
        while (i < n) begin
            o = map_op(stim_q[i]);
            j = i;
            while (j < n && map_op(stim_q[j]) == o) j++;
            run = j - i;
            while (run > 0) begin
                c = (run > LEN_MAX) ? LEN_MAX : run;
                exp_q.push_back(ent(o, c, 1'b0));
                run -= c;
            end
            i = j;
        end
        if (exp_q.size() == 0) begin
            exp_q.push_back(ent(2'b00, 0, 1'b1));
        end else begin
            tail = exp_q.pop_back();
            exp_q.push_back(tail | EW'(1));
        end
    endtask

    // Play stim_q as one alignment, drain, and compare against exp_q.
    task automatic run_alignment(input bit done_with_last, input bit rnd, input string tag);
        int budget;
        int n;
        bit rdy;
        got_q.delete();
        low_budget = 0;
        n = stim_q.size();
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            rdy = 1'b1;
            if (rnd) begin
                while ($urandom_range(0, 3) == 0)
                    cyc(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0, next_ready());
                rdy = next_ready();
            end
            cyc(1'b0, 1'b1, stim_q[i], done_with_last && (i == n - 1), rdy);
        end
        if (!done_with_last || n == 0)
            cyc(1'b0, 1'b0, 2'b00, 1'b1, rnd ? next_ready() : 1'b1);
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 60) begin
            cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
            budget++;
        end
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check({tag, " entries"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s entry%0d", tag, k), got_q[k], exp_q[k]);
        check({tag, " entry_count"}, entry_count_o, exp_q.size());
        check({tag, " overflow"}, overflow_o, 0);
        check({tag, " busy"}, busy_o, 0);
        check({tag, " valid"}, cigar_valid_o, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int            n;
        logic [1:0]    ops[8];
        bit            dwl;
        int            ne;
        logic [EW-1:0] exp[4];
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- vector table ----
        tbl[0].n = 6; tbl[0].ops = '{0, 0, 0, 2, 2, 3, 0, 0}; tbl[0].dwl = 0;
        tbl[0].ne = 3; tbl[0].exp = '{ent(0, 3, 0), ent(2, 2, 0), ent(3, 1, 1), '0};
        tbl[1].n = 0; tbl[1].ops = '{0, 0, 0, 0, 0, 0, 0, 0}; tbl[1].dwl = 0;
        tbl[1].ne = 1; tbl[1].exp = '{ent(0, 0, 1), '0, '0, '0};
        tbl[2].n = 2; tbl[2].ops = '{0, 1, 0, 0, 0, 0, 0, 0}; tbl[2].dwl = 1;
        tbl[3].n = 4; tbl[3].ops = '{0, 1, 0, 3, 0, 0, 0, 0}; tbl[3].dwl = 0;
        tbl[4].n = 1; tbl[4].ops = '{2, 0, 0, 0, 0, 0, 0, 0}; tbl[4].dwl = 1;
        tbl[4].ne = 1; tbl[4].exp = '{ent(2, 1, 1), '0, '0, '0};
        tbl[5].n = 3; tbl[5].ops = '{1, 1, 0, 0, 0, 0, 0, 0}; tbl[5].dwl = 1;
`ifdef CIGAR_MERGE_MISMATCH_EN
        tbl[2].ne = 1; tbl[2].exp = '{ent(0, 2, 1), '0, '0, '0};
        tbl[3].ne = 2; tbl[3].exp = '{ent(0, 3, 0), ent(3, 1, 1), '0, '0};
        tbl[5].ne = 1; tbl[5].exp = '{ent(0, 3, 1), '0, '0, '0};
`else
        tbl[2].ne = 2; tbl[2].exp = '{ent(0, 1, 0), ent(1, 1, 1), '0, '0};
        tbl[3].ne = 4; tbl[3].exp = '{ent(0, 1, 0), ent(1, 1, 0), ent(0, 1, 0), ent(3, 1, 1)};
        tbl[5].ne = 2; tbl[5].exp = '{ent(1, 2, 0), ent(0, 1, 1), '0, '0};
`endif

        // ---- reset ----
        repeat (2) @(posedge clk);
        #1;
        check("rst valid", cigar_valid_o, 0);
        check("rst busy", busy_o, 0);
        check("rst overflow", overflow_o, 0);
        check("rst entry_count", entry_count_o, 0);
        check("rst head", head(), 0);
        reset_i = 1'b1;
        cyc(1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        check("idle ignores op/done", cigar_valid_o, 0);

        // ---- table ----
        for (int v = 0; v < 6; v++) begin
            stim_q.delete();
            for (int i = 0; i < tbl[v].n; i++) stim_q.push_back(tbl[v].ops[i]);
            exp_q.delete();
            for (int i = 0; i < tbl[v].ne; i++) exp_q.push_back(tbl[v].exp[i]);
            run_alignment(tbl[v].dwl, 1'b0, $sformatf("vec%0d", v));
        end

        // ---- run-length saturation: 4096 matches ----
        stim_q.delete();
        for (int i = 0; i < 4096; i++) stim_q.push_back(2'b00);
        exp_q.delete();
        exp_q.push_back(ent(0, LEN_MAX, 0));
        exp_q.push_back(ent(0, 1, 1));
        run_alignment(1'b0, 1'b0, "maxrun");

        // ---- done with a run-closing op: final entry one cycle later ----
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
        check("coll valid", cigar_valid_o, 1);
        check("coll head0", head(), ent(0, 1, 0));
        check("coll busy flush", busy_o, 1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("coll head1", head(), ent(2, 1, 1));
        check("coll busy idle", busy_o, 0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("coll drained", cigar_valid_o, 0);
        check("coll entry_count", entry_count_o, 2);

        // ---- plain done: final entry visible one cycle after done ----
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        check("lat no entry yet", cigar_valid_o, 0);
        cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("lat valid", cigar_valid_o, 1);
        check("lat head", head(), ent(3, 1, 1));
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        check("lat busy", busy_o, 0);
        check("lat flush ignores op", entry_count_o, 1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        // ---- full FIFO: push+pop, then dropped last entry ----
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0);
        check("full entry_count", entry_count_o, 8);
        check("full no overflow", overflow_o, 0);
        check("full head", head(), ent(2, 1, 0));
        cyc(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
        check("pushpop overflow", overflow_o, 0);
        check("pushpop entry_count", entry_count_o, 9);
        check("pushpop head", head(), ent(3, 1, 0));
        cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("drop overflow", overflow_o, 1);
        check("drop entry_count", entry_count_o, 9);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drop head%0d", i), head(), ent((i % 2 == 0) ? 3 : 2, 1, 0));
            cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        end
        check("drop overflow sticky", overflow_o, 1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        check("abort valid", cigar_valid_o, 0);
        check("abort overflow", overflow_o, 0);
        check("abort entry_count", entry_count_o, 0);
        check("abort busy", busy_o, 1);
        cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("abort marker", head(), ent(0, 0, 1));
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        // ---- randomized alignments vs reference model ----
        for (int t = 0; t < 30; t++) begin
            int n;
            logic [1:0] prev;
            stim_q.delete();
            n = $urandom_range(0, 40);
            prev = 2'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) prev = 2'($urandom_range(0, 3));
                stim_q.push_back(prev);
            end
            build_expected();
            run_alignment(1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", t));
        end

        // ---- asynchronous reset mid-alignment ----
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        #2;
        reset_i = 1'b0;
        #1;
        check("arst valid", cigar_valid_o, 0);
        check("arst busy", busy_o, 0);
        check("arst entry_count", entry_count_o, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
